iob_reg_slice_iob_iob: RTL and testbench
========================================

// Module: iob_reg_slice_iob_iob
// PURPOSE
//  IOb-to-IOb pipeline converter: breaks the combinational path between a manager and a subordinate.
//  - Request path: 2-entry skid buffer, so iob_ready_o is registered.
//  - Response path: optional register stage.
//  - Read throttle: limits outstanding reads to MAX_RD_OUT.
//  Sits between interconnect stages, or in front of slow peripherals, to close timing.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width; must be a multiple of 8
//  MAX_RD_OUT  4   max reads issued downstream but not yet answered (>=1)
//  RSP_REG     1   1: register rvalid/rdata (+1 cycle); 0: combinational pass-through
// PORTS
//  clk_i         in   1         clock
//  cke_i         in   1         clock enable; 0 freezes all state
//  rst_i         in   1         synchronous reset, active-high
//  iob_valid_i   in   1         s-side request valid
//  iob_addr_i    in   ADDR_W    s-side address
//  iob_wdata_i   in   DATA_W    s-side write data
//  iob_wstrb_i   in   DATA_W/8  s-side write strobe; 0 = read
//  iob_rvalid_o  out  1         s-side read data valid
//  iob_rdata_o   out  DATA_W    s-side read data
//  iob_ready_o   out  1         s-side request accepted
//  iob_valid_o   out  1         m-side request valid
//  iob_addr_o    out  ADDR_W    m-side address
//  iob_wdata_o   out  DATA_W    m-side write data
//  iob_wstrb_o   out  DATA_W/8  m-side write strobe
//  iob_rvalid_i  in   1         m-side read data valid
//  iob_rdata_i   in   DATA_W    m-side read data
//  iob_ready_i   in   1         m-side request accepted
//  rd_cnt_o      out  $clog2(MAX_RD_OUT+1)  current outstanding-read count
//  err_o         out  1         sticky: rvalid_i seen with zero reads outstanding
// BEHAVIOUR
//  Interface: one clock, clk_i. Reset rst_i is synchronous and active-high and takes priority over cke_i.
//  Reset values:
//   - Buffer empty, so iob_valid_o=0 and iob_ready_o=1 the cycle after reset.
//   - rd_cnt_o=0, err_o=0, iob_rvalid_o=0, iob_rdata_o=0.
//   - addr/wdata/wstrb outputs=0.
//  Reset mid-transfer: buffered requests are dropped and the outstanding count is cleared.
//  Responses arriving after reset set err_o, because rd_cnt is 0.
//  Skid buffer (main and skid entries):
//   - s-side accept = iob_valid_i & iob_ready_o.
//   - iob_ready_o = ~skid_full, and is a register output.
//   - Accepted requests appear on the m-side no earlier than the next cycle.
//   - Strict FIFO order; no request is dropped or duplicated.
//   - Full (2 entries): iob_ready_o=0.
//   - Simultaneous s-accept and m-accept while full is impossible.
//   - Simultaneous s-accept and m-accept with 1 entry: the entry count stays 1.
//  Throttle:
//   - head_rd = head valid & head wstrb==0.
//   - iob_valid_o = head_valid & ~(head_rd & rd_cnt==MAX_RD_OUT).
//   - Writes are never throttled, but they queue behind a blocked read (in order).
//  Outstanding counter:
//   - +1 on m-accept of a read; -1 on iob_rvalid_i.
//   - Both in the same cycle: unchanged.
//   - Never exceeds MAX_RD_OUT.
//   - rvalid_i at count 0: count stays 0 and err_o is set until reset.
//  Response path:
//   - RSP_REG=1: rvalid_o/rdata_o = rvalid_i/rdata_i delayed by 1 cycle.
//   - RSP_REG=0: direct wires.
//   - The response path has no backpressure (IOb): every rvalid_i pulse is forwarded exactly once.
//  Writes generate no response.
//  m-side outputs hold stable while iob_valid_o=1 & iob_ready_i=0.
//  cke_i=0: no state changes. Handshakes are not counted, so iob_valid_i/iob_ready_i must be held by the partners.
// TESTING
//  T1 Back-to-back:
//   - ready_i=1; 8 writes addr 0x0..0x1C on consecutive cycles.
//   - Required: 8 m-side writes in order, each 1 cycle later; ready_o never drops.
//  T2 Backpressure:
//   - ready_i=0 for 5 cycles while 3 requests are offered.
//   - Required: 2 accepted, then ready_o=0.
//   - Required on release: both drain in order and the 3rd is accepted.
//  T3 Throttle:
//   - MAX_RD_OUT=4; 6 reads; rvalid_i withheld.
//   - Required: rd_cnt_o reaches 4 and valid_o=0.
//   - Required: one rvalid_i releases the 5th read.
//  T4 Same-cycle accept+response:
//   - Read m-accept in the same cycle as rvalid_i at rd_cnt=2.
//   - Required: rd_cnt_o stays 2.
//   - Required: RSP_REG=1 gives rvalid_o 1 cycle later with rdata 0xDEADBEEF.
//  T5 Spurious response:
//   - rvalid_i with rd_cnt=0.
//   - Required: err_o=1 and held; rd_cnt_o=0.
//  T6 Reset mid-op:
//   - Assert rst_i with 2 entries buffered and 3 reads outstanding.
//   - Required next cycle: valid_o=0, ready_o=1, rd_cnt_o=0, err_o=0.

Source files
------------

// File: rtl/iob_reg_slice_iob_iob.sv
// IOb-to-IOb register slice: 2-entry skid buffer on the request path (registered ready),
// optional response register, and a throttle on the number of outstanding reads.
module iob_reg_slice_iob_iob #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_RD_OUT = 4,
    parameter int RSP_REG    = 1
) (
    input  logic                               clk_i,
    input  logic                               cke_i,
    input  logic                               rst_i,
    input  logic                               iob_valid_i,
    input  logic [ADDR_W-1:0]                  iob_addr_i,
    input  logic [DATA_W-1:0]                  iob_wdata_i,
    input  logic [DATA_W/8-1:0]                iob_wstrb_i,
    output logic                               iob_rvalid_o,
    output logic [DATA_W-1:0]                  iob_rdata_o,
    output logic                               iob_ready_o,
    output logic                               iob_valid_o,
    output logic [ADDR_W-1:0]                  iob_addr_o,
    output logic [DATA_W-1:0]                  iob_wdata_o,
    output logic [DATA_W/8-1:0]                iob_wstrb_o,
    input  logic                               iob_rvalid_i,
    input  logic [DATA_W-1:0]                  iob_rdata_i,
    input  logic                               iob_ready_i,
    output logic [$clog2(MAX_RD_OUT+1)-1:0]    rd_cnt_o,
    output logic                               err_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_RD_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RD_OUT);

    logic              head_vld_q, head_vld_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d;
    logic [DATA_W-1:0] head_wdata_q, head_wdata_d;
    logic [STRB_W-1:0] head_wstrb_q, head_wstrb_d;
    logic              skid_vld_q, skid_vld_d;
    logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
    logic [DATA_W-1:0] skid_wdata_q, skid_wdata_d;
    logic [STRB_W-1:0] skid_wstrb_q, skid_wstrb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic head_rd;
    logic s_acc;
    logic m_acc;
    logic rd_inc;

    // A read at the head stalls while the outstanding budget is used up; writes behind it wait.
    assign head_rd     = head_vld_q & (head_wstrb_q == '0);
    assign iob_valid_o = head_vld_q & ~(head_rd & (cnt_q == MAX_CNT));
    assign iob_ready_o = ~skid_vld_q;
    assign s_acc       = iob_valid_i & ~skid_vld_q;
    assign m_acc       = iob_valid_o & iob_ready_i;
    assign rd_inc      = m_acc & head_rd;

    assign iob_addr_o  = head_addr_q;
    assign iob_wdata_o = head_wdata_q;
    assign iob_wstrb_o = head_wstrb_q;
    assign rd_cnt_o    = cnt_q;
    assign err_o       = err_q;

    always_comb begin
        head_vld_d   = head_vld_q;
        head_addr_d  = head_addr_q;
        head_wdata_d = head_wdata_q;
        head_wstrb_d = head_wstrb_q;
        skid_vld_d   = skid_vld_q;
        skid_addr_d  = skid_addr_q;
        skid_wdata_d = skid_wdata_q;
        skid_wstrb_d = skid_wstrb_q;
        if (head_vld_q && !m_acc) begin
            if (s_acc) begin
                skid_vld_d   = 1'b1;
                skid_addr_d  = iob_addr_i;
                skid_wdata_d = iob_wdata_i;
                skid_wstrb_d = iob_wstrb_i;
            end
        end else if (skid_vld_q) begin
            // Head leaves while the skid entry waits: promote it (no s-accept possible when full).
            head_vld_d   = 1'b1;
            head_addr_d  = skid_addr_q;
            head_wdata_d = skid_wdata_q;
            head_wstrb_d = skid_wstrb_q;
            skid_vld_d   = 1'b0;
        end else if (s_acc) begin
            head_vld_d   = 1'b1;
            head_addr_d  = iob_addr_i;
            head_wdata_d = iob_wdata_i;
            head_wstrb_d = iob_wstrb_i;
        end else begin
            head_vld_d   = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | (iob_rvalid_i & (cnt_q == '0));
        if (rd_inc && !iob_rvalid_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (iob_rvalid_i && !rd_inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_vld_q   <= 1'b0;
            head_addr_q  <= '0;
            head_wdata_q <= '0;
            head_wstrb_q <= '0;
            skid_vld_q   <= 1'b0;
            skid_addr_q  <= '0;
            skid_wdata_q <= '0;
            skid_wstrb_q <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else if (cke_i) begin
            head_vld_q   <= head_vld_d;
            head_addr_q  <= head_addr_d;
            head_wdata_q <= head_wdata_d;
            head_wstrb_q <= head_wstrb_d;
            skid_vld_q   <= skid_vld_d;
            skid_addr_q  <= skid_addr_d;
            skid_wdata_q <= skid_wdata_d;
            skid_wstrb_q <= skid_wstrb_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    generate
        if (RSP_REG != 0) begin : g_rsp_reg
            logic              rvalid_q;
            logic [DATA_W-1:0] rdata_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else if (cke_i) begin
                    rvalid_q <= iob_rvalid_i;
                    rdata_q  <= iob_rdata_i;
                end
            end
            assign iob_rvalid_o = rvalid_q;
            assign iob_rdata_o  = rdata_q;
        end else begin : g_rsp_wire
            assign iob_rvalid_o = iob_rvalid_i;
            assign iob_rdata_o  = iob_rdata_i;
        end
    endgenerate

endmodule

// File: tb/tb_iob_reg_slice_iob_iob.sv
// Bench for iob_reg_slice_iob_iob: directed scenarios plus random traffic, all checked each
// cycle against a queue-based model of the slice.
module tb_iob_reg_slice_iob_iob;
    localparam int MAX_RD = 4;
    localparam int CNT_W  = $clog2(MAX_RD + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              cke, rst, v_i, rdy_i, rv_i;
    logic [31:0]       a_i, wd_i, rd_i;
    logic [3:0]        ws_i;
    logic              iob_rvalid_o, iob_ready_o, iob_valid_o, err_o;
    logic [31:0]       iob_rdata_o, iob_addr_o, iob_wdata_o;
    logic [3:0]        iob_wstrb_o;
    logic [CNT_W-1:0]  rd_cnt_o;

    iob_reg_slice_iob_iob #(
        .ADDR_W(32), .DATA_W(32), .MAX_RD_OUT(MAX_RD), .RSP_REG(1)
    ) dut (
        .clk_i(clk), .cke_i(cke), .rst_i(rst),
        .iob_valid_i(v_i), .iob_addr_i(a_i), .iob_wdata_i(wd_i), .iob_wstrb_i(ws_i),
        .iob_rvalid_o(iob_rvalid_o), .iob_rdata_o(iob_rdata_o), .iob_ready_o(iob_ready_o),
        .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
        .iob_wstrb_o(iob_wstrb_o), .iob_rvalid_i(rv_i), .iob_rdata_i(rd_i),
        .iob_ready_i(rdy_i), .rd_cnt_o(rd_cnt_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
    } req_t;

    // Model: requests in flight inside the slice, outstanding reads, sticky error, response delay.
    req_t        mq[$];
    int          m_cnt = 0;
    bit          m_err = 1'b0;
    logic        m_rv  = 1'b0;
    logic [31:0] m_rd  = 32'h0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit ck, input bit v, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws, input bit rdy,
                       input bit rv, input logic [31:0] rd);
        bit   exp_rdy, head_rd, exp_vld, macc, sacc, inc;
        req_t nr;
        rst = r; cke = ck; v_i = v; a_i = a; wd_i = wd; ws_i = ws;
        rdy_i = rdy; rv_i = rv; rd_i = rd;
        #1;
        exp_rdy = (mq.size() < 2);
        head_rd = (mq.size() > 0) && (mq[0].ws == 4'h0);
        exp_vld = (mq.size() > 0) && !(head_rd && (m_cnt == MAX_RD));
        chk("ready_o", 64'(iob_ready_o), 64'(exp_rdy));
        chk("valid_o", 64'(iob_valid_o), 64'(exp_vld));
        chk("rd_cnt_o", 64'(rd_cnt_o), 64'(m_cnt));
        chk("err_o", 64'(err_o), 64'(m_err));
        chk("rvalid_o", 64'(iob_rvalid_o), 64'(m_rv));
        chk("rdata_o", 64'(iob_rdata_o), 64'(m_rd));
        if (mq.size() > 0) begin
            chk("addr_o", 64'(iob_addr_o), 64'(mq[0].a));
            chk("wdata_o", 64'(iob_wdata_o), 64'(mq[0].wd));
            chk("wstrb_o", 64'(iob_wstrb_o), 64'(mq[0].ws));
        end
        if (r) begin
            mq.delete();
            m_cnt = 0; m_err = 1'b0; m_rv = 1'b0; m_rd = 32'h0;
        end else if (ck) begin
            macc = exp_vld && rdy;
            sacc = v && exp_rdy;
            inc  = macc && head_rd;
            if (rv && m_cnt == 0) m_err = 1'b1;
            if (inc && !rv) m_cnt++;
            else if (rv && !inc && m_cnt > 0) m_cnt--;
            if (macc) void'(mq.pop_front());
            if (sacc) begin
                nr.a = a; nr.wd = wd; nr.ws = ws;
                mq.push_back(nr);
            end
            m_rv = rv; m_rd = rd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cyc(0, 1, 0, 32'h0, 32'h0, 4'h0, rdy, 0, $urandom);
    endtask

    task automatic drain_rsp(input int n);
        for (int k = 0; k < n; k++) cyc(0, 1, 0, 32'h0, 32'h0, 4'h0, 1, (m_cnt > 0), $urandom);
    endtask

    req_t        t2[3];
    int          idx;
    bit          acc, ck, rv, v, rdy;
    logic [3:0]  ws;

    initial begin
        rst = 1'b1; cke = 1'b1; v_i = 1'b0; a_i = '0; wd_i = '0; ws_i = '0;
        rdy_i = 1'b0; rv_i = 1'b0; rd_i = '0;
        @(posedge clk);
        #1;
        cyc(1, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
        chk("rst_addr_o", 64'(iob_addr_o), 64'h0);
        chk("rst_wdata_o", 64'(iob_wdata_o), 64'h0);
        chk("rst_wstrb_o", 64'(iob_wstrb_o), 64'h0);
        chk("rst_ready_o", 64'(iob_ready_o), 64'h1);
        chk("rst_valid_o", 64'(iob_valid_o), 64'h0);

        // T1: back-to-back writes
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 32'(i * 4), $urandom, 4'hF, 1, 0, $urandom);
        idle(2, 1);

        // T2: backpressure with three offered writes
        for (int i = 0; i < 3; i++) begin
            t2[i].a  = 32'h40 + 32'(i * 4);
            t2[i].wd = $urandom;
            t2[i].ws = 4'(1 + $urandom_range(0, 14));
        end
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            acc = (mq.size() < 2);
            cyc(0, 1, 1, t2[idx].a, t2[idx].wd, t2[idx].ws, 0, 0, $urandom);
            if (acc) idx++;
        end
        chk("t2_ready_low", 64'(iob_ready_o), 64'h0);
        chk("t2_valid_held", 64'(iob_valid_o), 64'h1);
        for (int c = 0; c < 6; c++) begin
            if (idx < 3) begin
                acc = (mq.size() < 2);
                cyc(0, 1, 1, t2[idx].a, t2[idx].wd, t2[idx].ws, 1, 0, $urandom);
                if (acc) idx++;
            end else begin
                idle(1, 1);
            end
        end

        // T3: read throttle at MAX_RD outstanding
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 6) begin
                acc = (mq.size() < 2);
                cyc(0, 1, 1, 32'h100 + 32'(idx * 4), $urandom, 4'h0, 1, 0, $urandom);
                if (acc) idx++;
            end else begin
                idle(1, 1);
            end
        end
        chk("t3_rd_cnt_max", 64'(rd_cnt_o), 64'(MAX_RD));
        chk("t3_throttled", 64'(iob_valid_o), 64'h0);
        cyc(0, 1, 0, 32'h0, 32'h0, 4'h0, 1, 1, $urandom);
        chk("t3_released", 64'(iob_valid_o), 64'h1);
        drain_rsp(10);

        // T4: read accept coinciding with a response at two outstanding
        cyc(0, 1, 1, 32'h200, 32'h0, 4'h0, 1, 0, $urandom);
        cyc(0, 1, 1, 32'h204, 32'h0, 4'h0, 1, 0, $urandom);
        cyc(0, 1, 1, 32'h208, 32'h0, 4'h0, 1, 0, $urandom);
        cyc(0, 1, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'hDEADBEEF);
        chk("t4_rd_cnt", 64'(rd_cnt_o), 64'h2);
        chk("t4_rvalid_o", 64'(iob_rvalid_o), 64'h1);
        chk("t4_rdata_o", 64'(iob_rdata_o), 64'hDEADBEEF);
        drain_rsp(3);

        // Random traffic including clock-enable stalls
        for (int c = 0; c < 400; c++) begin
            ck  = ($urandom_range(0, 7) != 0);
            rv  = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            v   = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            cyc(0, ck, v, $urandom, $urandom, ws, rdy, rv, $urandom);
        end
        drain_rsp(20);
        chk("pre_t5_err", 64'(err_o), 64'h0);

        // T5: spurious response
        cyc(0, 1, 0, 32'h0, 32'h0, 4'h0, 1, 1, $urandom);
        chk("t5_err_set", 64'(err_o), 64'h1);
        idle(3, 1);
        chk("t5_err_held", 64'(err_o), 64'h1);
        chk("t5_rd_cnt", 64'(rd_cnt_o), 64'h0);

        // T6: reset with a full buffer and three reads outstanding
        cyc(0, 1, 1, 32'h300, 32'h0, 4'h0, 1, 0, $urandom);
        cyc(0, 1, 1, 32'h304, 32'h0, 4'h0, 1, 0, $urandom);
        cyc(0, 1, 1, 32'h308, 32'h0, 4'h0, 1, 0, $urandom);
        idle(1, 1);
        cyc(0, 1, 1, 32'h30C, $urandom, 4'hF, 0, 0, $urandom);
        cyc(0, 1, 1, 32'h310, $urandom, 4'h3, 0, 0, $urandom);
        chk("t6_pre_cnt", 64'(rd_cnt_o), 64'h3);
        chk("t6_pre_full", 64'(iob_ready_o), 64'h0);
        cyc(1, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0, $urandom);
        chk("t6_valid_o", 64'(iob_valid_o), 64'h0);
        chk("t6_ready_o", 64'(iob_ready_o), 64'h1);
        chk("t6_rd_cnt", 64'(rd_cnt_o), 64'h0);
        chk("t6_err_o", 64'(err_o), 64'h0);
        cyc(0, 1, 0, 32'h0, 32'h0, 4'h0, 1, 1, $urandom);
        chk("t6_late_rsp_err", 64'(err_o), 64'h1);
        idle(2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
